// File: rtl/bids_round_sequencer.sv
// Host-side sequencer for one bids22 auction round: loads balances and config,
// locks the engine, pulses c_start, waits for winner resolution, then unlocks.
module bids_round_sequencer #(
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned NUMBIDDERS = 3,
  parameter int unsigned LENW       = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATAWIDTH-1:0]  cfg_x,
  input  logic [DATAWIDTH-1:0]  cfg_y,
  input  logic [DATAWIDTH-1:0]  cfg_z,
  input  logic [NUMBIDDERS-1:0] cfg_mask,
  input  logic [DATAWIDTH-1:0]  cfg_timer,
  input  logic [DATAWIDTH-1:0]  cfg_charge,
  input  logic [DATAWIDTH-1:0]  cfg_key,
  input  logic [LENW-1:0]       cfg_round_len,
  output logic [3:0]            c_op,
  output logic [DATAWIDTH-1:0]  c_data,
  output logic                  c_start,
  input  logic                  e_ready,
  input  logic [2:0]            e_err,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            done_status,
  output logic [2:0]            done_err
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  localparam logic [3:0] OpNoOp        = 4'd0;
  localparam logic [3:0] OpUnlock      = 4'd1;
  localparam logic [3:0] OpLock        = 4'd2;
  localparam logic [3:0] OpLoadx       = 4'd3;
  localparam logic [3:0] OpLoady       = 4'd4;
  localparam logic [3:0] OpLoadz       = 4'd5;
  localparam logic [3:0] OpSetMask     = 4'd6;
  localparam logic [3:0] OpSetTimer    = 4'd7;
  localparam logic [3:0] OpSetCharge   = 4'd8;

  localparam logic [1:0] StatOk      = 2'd0;
  localparam logic [1:0] StatCfgErr  = 2'd1;
  localparam logic [1:0] StatTimeout = 2'd2;

  typedef enum logic [3:0] {
    StIdle, StLdx, StLdy, StLdz, StMask, StTimer, StCharge, StLock,
    StRound, StWaitDone, StUnlock, StFin, StAbort
  } state_t;

  state_t state;
  state_t cfg_next_state;
  logic [3:0]            cfg_next_op;
  logic [DATAWIDTH-1:0]  cfg_next_data;

  logic [DATAWIDTH-1:0]  y_q, z_q, timer_q, charge_q, key_q;
  logic [NUMBIDDERS-1:0] mask_q;
  logic [LENW-1:0]       len_q;
  logic [LENW-1:0]       round_cnt;
  logic [WaitW-1:0]      wait_cnt;
  logic                  seen_low;
  logic                  resolved;

  assign cfg_ready = (state == StIdle);

  // Successor state and command for each config-phase state (LDX..LOCK).
  always_comb begin
    cfg_next_state = StIdle;
    cfg_next_op    = OpNoOp;
    cfg_next_data  = '0;
    case (state)
      StLdx:    begin cfg_next_state = StLdy;    cfg_next_op = OpLoady;     cfg_next_data = y_q;      end
      StLdy:    begin cfg_next_state = StLdz;    cfg_next_op = OpLoadz;     cfg_next_data = z_q;      end
      StLdz:    begin
        cfg_next_state = StMask;
        cfg_next_op    = OpSetMask;
        cfg_next_data  = DATAWIDTH'(mask_q);
      end
      StMask:   begin cfg_next_state = StTimer;  cfg_next_op = OpSetTimer;  cfg_next_data = timer_q;  end
      StTimer:  begin cfg_next_state = StCharge; cfg_next_op = OpSetCharge; cfg_next_data = charge_q; end
      StCharge: begin cfg_next_state = StLock;   cfg_next_op = OpLock;      cfg_next_data = key_q;    end
      StLock:   begin cfg_next_state = StRound;  cfg_next_op = OpNoOp;      cfg_next_data = '0;       end
      default:  ;
    endcase
  end

  // Round FSM; outputs are registered from the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      c_op        <= OpNoOp;
      c_data      <= '0;
      c_start     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_status <= StatOk;
      done_err    <= 3'd0;
      y_q         <= '0;
      z_q         <= '0;
      timer_q     <= '0;
      charge_q    <= '0;
      key_q       <= '0;
      mask_q      <= '0;
      len_q       <= '0;
      round_cnt   <= '0;
      wait_cnt    <= '0;
      seen_low    <= 1'b0;
      resolved    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cfg_valid) begin
            y_q      <= cfg_y;
            z_q      <= cfg_z;
            mask_q   <= cfg_mask;
            timer_q  <= cfg_timer;
            charge_q <= cfg_charge;
            key_q    <= cfg_key;
            len_q    <= cfg_round_len;
            state    <= StLdx;
            c_op     <= OpLoadx;
            c_data   <= cfg_x;
            busy     <= 1'b1;
          end
        end
        StLdx, StLdy, StLdz, StMask, StTimer, StCharge, StLock: begin
          if (e_err != 3'd0) begin
            // Engine rejected the command: report and leave it as-is.
            state       <= StAbort;
            c_op        <= OpNoOp;
            c_data      <= '0;
            done        <= 1'b1;
            done_status <= StatCfgErr;
            done_err    <= e_err;
          end else begin
            state  <= cfg_next_state;
            c_op   <= cfg_next_op;
            c_data <= cfg_next_data;
            if (state == StLock) begin
              c_start   <= 1'b1;
              round_cnt <= (len_q == '0) ? LENW'(1) : len_q;
            end
          end
        end
        StRound: begin
          if (round_cnt == LENW'(1)) begin
            state    <= StWaitDone;
            c_start  <= 1'b0;
            wait_cnt <= '0;
            seen_low <= 1'b0;
            resolved <= 1'b0;
          end else begin
            round_cnt <= round_cnt - LENW'(1);
          end
        end
        StWaitDone: begin
          wait_cnt <= wait_cnt + WaitW'(1);
          if (resolved) begin
            // One cycle after ready returned high (engine READYNEXT).
            state  <= StUnlock;
            c_op   <= OpUnlock;
            c_data <= key_q;
          end else if (wait_cnt == WaitLast) begin
            state       <= StAbort;
            done        <= 1'b1;
            done_status <= StatTimeout;
            done_err    <= 3'd0;
          end else if (!e_ready) begin
            seen_low <= 1'b1;
          end else if (seen_low) begin
            resolved <= 1'b1;
          end
        end
        StUnlock: begin
          state       <= StFin;
          c_op        <= OpNoOp;
          c_data      <= '0;
          done        <= 1'b1;
          done_status <= StatOk;
          done_err    <= 3'd0;
        end
        StFin, StAbort: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bids_round_sequencer.sv
// Scoreboard bench for bids_round_sequencer: directed rounds push expected
// engine commands, c_start run lengths and completions; a monitor checks them.
module tb_bids_round_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_x, cfg_y, cfg_z, cfg_timer, cfg_charge, cfg_key;
  logic [2:0]  cfg_mask;
  logic [15:0] cfg_round_len;
  logic [3:0]  c_op;
  logic [31:0] c_data;
  logic        c_start;
  logic        e_ready;
  logic [2:0]  e_err;
  logic        busy;
  logic        done;
  logic [1:0]  done_status;
  logic [2:0]  done_err;

  always #5 clk = ~clk;

  bids_round_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_z(cfg_z), .cfg_mask(cfg_mask),
    .cfg_timer(cfg_timer), .cfg_charge(cfg_charge), .cfg_key(cfg_key),
    .cfg_round_len(cfg_round_len),
    .c_op(c_op), .c_data(c_data), .c_start(c_start),
    .e_ready(e_ready), .e_err(e_err),
    .busy(busy), .done(done), .done_status(done_status), .done_err(done_err)
  );

  localparam int EvOp = 0, EvStart = 1, EvDone = 2;
  localparam int ModeOk = 0, ModeTimeout = 1, ModeCfgErr = 2, ModeReset = 3;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    int          gap;  // cycles from c_start fall to done; -1 = not applicable
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push(int kind, logic [31:0] a, logic [31:0] b, int gap);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.gap = gap;
    sb.push_back(e);
  endfunction

  // Expected events for one round, hand-derived from the command sequence.
  task automatic push_round(input logic [31:0] x, y, z, input logic [2:0] mask,
                            input logic [31:0] timer, charge, key,
                            input logic [15:0] len, input int mode);
    push(EvOp, 3, x, -1);
    push(EvOp, 4, y, -1);
    push(EvOp, 5, z, -1);
    push(EvOp, 6, {29'd0, mask}, -1);
    if (mode == ModeCfgErr) begin
      push(EvDone, 1, 3, -1);
      return;
    end
    push(EvOp, 7, timer, -1);
    push(EvOp, 8, charge, -1);
    push(EvOp, 2, key, -1);
    if (mode == ModeReset) begin
      push(EvStart, 2, 0, -1);
      return;
    end
    push(EvStart, (len == 16'd0) ? 32'd1 : {16'd0, len}, 0, -1);
    if (mode == ModeOk) begin
      push(EvOp, 1, key, -1);
      push(EvDone, 0, 0, 5);
    end else begin
      push(EvDone, 2, 0, 64);
    end
  endtask

  // Monitor: every observable engine command / start run / done is scored.
  int run_len = 0;
  int gap_cnt = 0;
  always @(negedge clk) begin
    ev_t e;
    if (c_start) begin
      run_len++;
    end else if (run_len > 0) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_start: run %0d, nothing expected", run_len);
      end else begin
        e = sb.pop_front();
        chk("start_kind", EvStart, e.kind);
        chk("start_len", run_len, e.a);
      end
      run_len = 0;
      gap_cnt = 0;
    end else begin
      gap_cnt++;
    end
    if (c_op != 4'd0) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_op: op %0d data 0x%0h, nothing expected", c_op, c_data);
      end else begin
        e = sb.pop_front();
        chk("op_kind", e.kind, EvOp);
        chk("op_code", {28'd0, c_op}, e.a);
        chk("op_data", c_data, e.b);
      end
    end
    if (done) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: status %0d, nothing expected", done_status);
      end else begin
        e = sb.pop_front();
        chk("done_kind", e.kind, EvDone);
        chk("done_status", {30'd0, done_status}, e.a);
        chk("done_err", {29'd0, done_err}, e.b);
        if (e.gap >= 0) chk("done_latency", gap_cnt, e.gap);
      end
    end
  end

  task automatic set_cfg(input logic [31:0] x, y, z, input logic [2:0] mask,
                         input logic [31:0] timer, charge, key, input logic [15:0] len);
    cfg_x = x; cfg_y = y; cfg_z = z; cfg_mask = mask;
    cfg_timer = timer; cfg_charge = charge; cfg_key = key; cfg_round_len = len;
  endtask

  // Present one request for a single cycle, then scramble the fields.
  task automatic issue();
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    set_cfg(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b010,
            32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'h7777);
  endtask

  task automatic wait_start_rise(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (c_start) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_start_rise: c_start never rose, expected within %0d", budget);
  endtask

  task automatic wait_start_fall(input int budget);
    bit was_high = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (c_start) was_high = 1;
      else if (was_high) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_start_fall: c_start never fell, expected within %0d", budget);
  endtask

  task automatic wait_op(input logic [3:0] op, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (c_op == op) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_op: op %0d not seen, expected within %0d", op, budget);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_done: done not seen, expected within %0d", budget);
  endtask

  // Engine winner resolution: ready low for one cycle shortly after c_start falls.
  task automatic ready_pulse();
    wait_start_fall(70000);
    @(negedge clk);
    e_ready = 1'b0;
    @(negedge clk);
    e_ready = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; cfg_valid = 1'b0; e_ready = 1'b1; e_err = 3'd0;
    set_cfg(0, 0, 0, 3'b000, 0, 0, 0, 16'd0);
    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_c_op", c_op, 0);
    chk("rst_c_data", c_data, 0);
    chk("rst_c_start", c_start, 0);
    chk("rst_done", done, 0);
    chk("rst_done_status", done_status, 0);
    chk("rst_done_err", done_err, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Nominal round.
    set_cfg(100, 50, 20, 3'b111, 15, 1, 32'hA5, 16'd4);
    push_round(100, 50, 20, 3'b111, 15, 1, 32'hA5, 16'd4, ModeOk);
    issue();
    chk("nom_busy", busy, 1);
    chk("nom_cfg_ready_busy", cfg_ready, 0);
    ready_pulse();
    wait_done(50);
    @(negedge clk);
    chk("nom_idle_ready", cfg_ready, 1);

    // Engine rejects SETMASK.
    set_cfg(1, 2, 3, 3'b011, 4, 5, 32'h66, 16'd4);
    push_round(1, 2, 3, 3'b011, 4, 5, 32'h66, 16'd4, ModeCfgErr);
    issue();
    wait_op(4'd6, 20);
    e_err = 3'd3;
    @(negedge clk);
    e_err = 3'd0;
    chk("err_done", done, 1);
    @(negedge clk);
    chk("err_ready_after", cfg_ready, 1);
    chk("err_busy_after", busy, 0);

    // Resolution never happens: timeout.
    set_cfg(9, 9, 9, 3'b001, 9, 9, 32'h99, 16'd4);
    push_round(9, 9, 9, 3'b001, 9, 9, 32'h99, 16'd4, ModeTimeout);
    issue();
    wait_done(200);
    chk("to_c_start", c_start, 0);
    @(negedge clk);

    // Zero round length behaves as one cycle.
    set_cfg(11, 12, 13, 3'b100, 14, 15, 32'hC3, 16'd0);
    push_round(11, 12, 13, 3'b100, 14, 15, 32'hC3, 16'd0, ModeOk);
    issue();
    ready_pulse();
    wait_done(50);
    @(negedge clk);

    // Maximum round length; timeout still TIMEOUT cycles after c_start falls.
    set_cfg(21, 22, 23, 3'b110, 24, 25, 32'h5A, 16'hFFFF);
    push_round(21, 22, 23, 3'b110, 24, 25, 32'h5A, 16'hFFFF, ModeTimeout);
    issue();
    wait_done(70000);
    @(negedge clk);

    // Reset two cycles into a ten-cycle round.
    set_cfg(31, 32, 33, 3'b111, 34, 35, 32'h77, 16'd10);
    push_round(31, 32, 33, 3'b111, 34, 35, 32'h77, 16'd10, ModeReset);
    issue();
    wait_start_rise(30);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_c_start", c_start, 0);
    chk("arst_c_op", c_op, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_cfg_ready", cfg_ready, 1);
    chk("arst_busy", busy, 0);
    set_cfg(41, 42, 43, 3'b011, 44, 45, 32'h88, 16'd3);
    push_round(41, 42, 43, 3'b011, 44, 45, 32'h88, 16'd3, ModeOk);
    issue();
    ready_pulse();
    wait_done(50);
    @(negedge clk);

    // Back-to-back: cfg_valid held across two rounds.
    set_cfg(100, 200, 300, 3'b111, 1, 2, 32'hABCD, 16'd2);
    push_round(100, 200, 300, 3'b111, 1, 2, 32'hABCD, 16'd2, ModeOk);
    push_round(7, 8, 9, 3'b101, 2, 3, 32'h1234, 16'd2, ModeOk);
    cfg_valid = 1'b1;
    @(negedge clk);
    set_cfg(7, 8, 9, 3'b101, 2, 3, 32'h1234, 16'd2);
    ready_pulse();
    wait_done(50);
    chk("b2b_not_ready_on_done", cfg_ready, 0);
    @(negedge clk);
    chk("b2b_ready_after_done", cfg_ready, 1);
    @(negedge clk);
    chk("b2b_second_loadx", c_op, 3);
    chk("b2b_second_x", c_data, 7);
    cfg_valid = 1'b0;
    ready_pulse();
    wait_done(50);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bids_round_sequencer.md
Name: bids_round_sequencer

Overview:
- Host-side controller that drives the command port of the bids22 auction engine for one full auction round from a single configuration request.
- Issues the load/config opcode sequence, locks the engine with a key, holds C_start for a programmed number of cycles, and waits for the engine to finish winner resolution.
- Unlocks the engine afterwards and reports completion status to the requester.
- Sits between the system host (valid/ready config interface) and the engine's cin/cout signals.

Parameters:
- DATAWIDTH, 32, width of C_data and every config value.
- NUMBIDDERS, 3, mask width; loads are issued for bidders 0..2 (LOADX/LOADY/LOADZ).
- LENW, 16, width of the round-length field.
- TIMEOUT, 64, maximum cycles spent in WAIT_DONE before abort.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  requester has a round configuration.
- cfg_ready  out  1  sequencer accepts config; high only in IDLE.
- cfg_x, cfg_y, cfg_z  in  DATAWIDTH each  initial balances of bidders 0/1/2.
- cfg_mask  in  NUMBIDDERS  bidder enable mask.
- cfg_timer  in  DATAWIDTH  bad-key cooldown value.
- cfg_charge  in  DATAWIDTH  per-bid charge.
- cfg_key  in  DATAWIDTH  lock/unlock key.
- cfg_round_len  in  LENW  C_start high duration, in cycles.
- c_op  out  4  engine opcode.
- c_data  out  DATAWIDTH  engine data.
- c_start  out  1  engine round start.
- e_ready  in  1  engine cout.ready.
- e_err  in  3  engine cout.err (0 = NOERROR).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- done_status  out  2  0 OK, 1 CFG_ERR, 2 TIMEOUT; valid with done, held until the next done.
- done_err  out  3  e_err value captured on CFG_ERR, else 0.

Behaviour:
- Reset is asynchronous, active-low (reset_n); clock is clk. On reset: state=IDLE, c_op=0 (NO_OP), c_data=0, c_start=0, done=0, done_status=0, done_err=0, busy=0, cfg_ready=1. A reset asserted mid-round drops c_start immediately.
- Opcode encoding: NO_OP 0, UNLOCK 1, LOCK 2, LOADX 3, LOADY 4, LOADZ 5, SETMASK 6, SETTIMER 7, SETBIDCHARGE 8.
- c_op, c_data and c_start are registered, decoded from the current state.
- Handshake: when cfg_valid && cfg_ready, all cfg_* fields are latched and the state moves to LDX. cfg_* changes after acceptance have no effect.
- State sequence, one cycle per config state:
  - IDLE
  - LDX (LOADX, x)
  - LDY (LOADY, y)
  - LDZ (LOADZ, z)
  - MASK (SETMASK, mask zero-extended)
  - TIMER (SETTIMER)
  - CHARGE (SETBIDCHARGE)
  - LOCK (LOCK, key)
  - ROUND
  - WAIT_DONE
  - UNLOCK (UNLOCK, key)
  - FIN
  - IDLE
- Error check: in each config state LDX..LOCK, e_err is sampled the same cycle the opcode is driven.
  - If e_err != 0, go to ABORT: c_op=NO_OP, done=1, done_status=CFG_ERR, done_err=e_err.
  - The following cycle returns to IDLE.
  - The engine is left as-is; no UNLOCK is sent.
- ROUND:
  - c_op=NO_OP, c_start=1 for exactly max(cfg_round_len,1) consecutive cycles; cfg_round_len=0 is treated as 1.
  - The down-counter is LENW bits wide and is loaded on entry.
  - c_start falls on the cycle the state enters WAIT_DONE.
- WAIT_DONE:
  - c_start=0, c_op=NO_OP.
  - Waits until e_ready has been seen low and then high again (the engine's winner-resolution cycle).
  - Once e_ready is high again, spends 1 extra cycle (the engine's READYNEXT), then goes to UNLOCK.
  - A cycle counter starts at 0 on entry. If it reaches TIMEOUT first, go to ABORT with done_status=TIMEOUT, done_err=0.
  - e_ready low and high in the same sample is impossible; low is tracked by a sticky flag.
- UNLOCK: drives UNLOCK/key for one cycle. e_err is not checked here, since the engine reports only after returning to LOCKED.
- FIN: c_op=NO_OP, done=1, done_status=OK, then IDLE.
- cfg_valid in any non-IDLE state is ignored; cfg_ready=0 there.
- A new request accepted in IDLE in the cycle after done is legal (back-to-back rounds).

Test Plan:
- Nominal round: cfg x=100,y=50,z=20, mask=3'b111, timer=15, charge=1, key=0xA5, round_len=4 -> c_op sequence 3,4,5,6,7,8,2 on consecutive cycles with matching c_data; c_start high exactly 4 cycles; e_ready pulsed low 1 cycle 2 cycles later -> UNLOCK with c_data=0xA5, done=1 with status 0.
- Config error: e_err=3 while c_op=SETMASK -> next cycle done=1, done_status=1, done_err=3; no LOCK/UNLOCK issued; cfg_ready=1 the cycle after.
- Timeout: e_ready held high throughout WAIT_DONE -> done after exactly TIMEOUT=64 cycles, done_status=2, c_start=0, no UNLOCK.
- round_len=0 -> c_start high exactly 1 cycle; round_len=0xFFFF smoke check with TIMEOUT unaffected.
- Reset mid-ROUND (2 cycles into a 10-cycle round) -> c_start=0 and c_op=0 asynchronously; after release cfg_ready=1, busy=0, and a new request runs normally.
- Back-to-back: cfg_valid held high across two rounds -> second request accepted the cycle after done; cfg_valid asserted while busy is not accepted.
